bank_axi3_mem_slave: RTL and testbench

AXI3 responder (slave) memory for the bank BIU's bus side. It accepts AR/AW/W from the bank BIU master and returns R/B responses from an internal line-organised storage array. It is used as the bus-side model in bank-level simulation and as an on-chip scratch memory.
- Independent read and write engines.
- Responses are in order, one transaction outstanding per direction.

---
 rtl/bank_axi3_mem_slave.sv | 229 ++++++++++++++++++++++
 tb/tb_bank_axi3_mem_slave.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bank_axi3_mem_slave.sv
// rtl/bank_axi3_mem_slave.sv - AXI3 responder memory, one 256-bit line per beat
// Independent in-order read and write engines sharing a line-organised storage array.
module bank_axi3_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_axi3_arvalid_i,
  output logic                  s_axi3_arready_o,
  input  logic [ID_WIDTH-1:0]   s_axi3_arid_i,
  input  logic [ADDR_WIDTH-1:0] s_axi3_araddr_i,
  input  logic [2:0]            s_axi3_arsize_i,
  input  logic [3:0]            s_axi3_arlen_i,
  input  logic [1:0]            s_axi3_arburst_i,
  output logic                  s_axi3_rvalid_o,
  input  logic                  s_axi3_rready_i,
  output logic [ID_WIDTH-1:0]   s_axi3_rid_o,
  output logic [DATA_WIDTH-1:0] s_axi3_rdata_o,
  output logic [1:0]            s_axi3_rresp_o,
  output logic                  s_axi3_rlast_o,
  input  logic                  s_axi3_awvalid_i,
  output logic                  s_axi3_awready_o,
  input  logic [ID_WIDTH-1:0]   s_axi3_awid_i,
  input  logic [ADDR_WIDTH-1:0] s_axi3_awaddr_i,
  input  logic [2:0]            s_axi3_awsize_i,
  input  logic [3:0]            s_axi3_awlen_i,
  input  logic [1:0]            s_axi3_awburst_i,
  input  logic                  s_axi3_wvalid_i,
  output logic                  s_axi3_wready_o,
  input  logic [ID_WIDTH-1:0]   s_axi3_wid_i,
  input  logic [DATA_WIDTH-1:0] s_axi3_wdata_i,
  input  logic [STRB_WIDTH-1:0] s_axi3_wstrb_i,
  input  logic                  s_axi3_wlast_i,
  output logic                  s_axi3_bvalid_o,
  input  logic                  s_axi3_bready_i,
  output logic [ID_WIDTH-1:0]   s_axi3_bid_o,
  output logic [1:0]            s_axi3_bresp_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = 1;
  localparam logic [3:0]            BEAT_ONE = 4'd1;
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [DEPTH_LOG2-1:0] r_idx_q, r_idx_d;
  logic [3:0]            r_len_q, r_len_d;
  logic [3:0]            r_beat_q, r_beat_d;
  logic                  r_err_q, r_err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [DEPTH_LOG2-1:0] w_idx_q, w_idx_d;
  logic [3:0]            w_len_q, w_len_d;
  logic [3:0]            w_beat_q, w_beat_d;
  logic                  w_aerr_q, w_aerr_d;
  logic                  w_err_q, w_err_d;
  logic                  mem_we;

  logic                  ar_err, aw_err, w_last_beat;
  logic [DEPTH_LOG2-1:0] ar_idx, aw_idx;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi3_araddr_i[4:0], s_axi3_awaddr_i[4:0]};

  assign ar_idx = s_axi3_araddr_i[DEPTH_LOG2+4:5];
  assign aw_idx = s_axi3_awaddr_i[DEPTH_LOG2+4:5];
  assign ar_err = (s_axi3_arsize_i != 3'b101) || (s_axi3_arburst_i != 2'b01)
                  || (|s_axi3_araddr_i[ADDR_WIDTH-1:DEPTH_LOG2+5]);
  assign aw_err = (s_axi3_awsize_i != 3'b101) || (s_axi3_awburst_i != 2'b01)
                  || (|s_axi3_awaddr_i[ADDR_WIDTH-1:DEPTH_LOG2+5]);

  // Read engine: rdata_q is loaded on the accepting edge so every beat is zero-bubble.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_err_d   = r_err_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi3_arvalid_i) begin
          r_id_d    = s_axi3_arid_i;
          r_idx_d   = ar_idx;
          r_len_d   = s_axi3_arlen_i;
          r_beat_d  = 4'd0;
          r_err_d   = ar_err;
          rdata_d   = ar_err ? '0 : mem[ar_idx];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi3_rready_i) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_idx_d  = r_idx_q + IDX_ONE;
            r_beat_d = r_beat_q + BEAT_ONE;
            rdata_d  = r_err_q ? '0 : mem[r_idx_q + IDX_ONE];
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_err_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_err_q   <= r_err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axi3_arready_o = (r_state_q == R_IDLE);
  assign s_axi3_rvalid_o  = (r_state_q == R_DATA);
  assign s_axi3_rlast_o   = (r_state_q == R_DATA) && (r_beat_q == r_len_q);
  assign s_axi3_rid_o     = r_id_q;
  assign s_axi3_rdata_o   = rdata_q;
  assign s_axi3_rresp_o   = r_err_q ? RESP_SLVERR : RESP_OKAY;

  // Only the address-phase error blocks storage; protocol errors just poison the response.
  assign w_last_beat = (w_beat_q == w_len_q);

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_aerr_d  = w_aerr_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi3_awvalid_i) begin
          w_id_d    = s_axi3_awid_i;
          w_idx_d   = aw_idx;
          w_len_d   = s_axi3_awlen_i;
          w_beat_d  = 4'd0;
          w_aerr_d  = aw_err;
          w_err_d   = aw_err;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi3_wvalid_i) begin
          mem_we  = !w_aerr_q && !rst_i;
          w_err_d = w_err_q || (s_axi3_wlast_i != w_last_beat) || (s_axi3_wid_i != w_id_q);
          if (w_last_beat) begin
            w_state_d = W_RESP;
          end else begin
            w_idx_d  = w_idx_q + IDX_ONE;
            w_beat_d = w_beat_q + BEAT_ONE;
          end
        end
      end
      W_RESP: begin
        if (s_axi3_bready_i) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_aerr_q  <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_aerr_q  <= w_aerr_d;
      w_err_q   <= w_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi3_wstrb_i[b]) begin
          mem[w_idx_q][8*b +: 8] <= s_axi3_wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign s_axi3_awready_o = (w_state_q == W_IDLE);
  assign s_axi3_wready_o  = (w_state_q == W_DATA);
  assign s_axi3_bvalid_o  = (w_state_q == W_RESP);
  assign s_axi3_bid_o     = w_id_q;
  assign s_axi3_bresp_o   = w_err_q ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_bank_axi3_mem_slave.sv
// tb/tb_bank_axi3_mem_slave.sv - directed self-checking bench for bank_axi3_mem_slave
module tb_bank_axi3_mem_slave;

  logic         clk = 1'b0;
  logic         rst;
  logic         arvalid, arready, rvalid, rready, rlast;
  logic [7:0]   arid, rid;
  logic [31:0]  araddr;
  logic [2:0]   arsize;
  logic [3:0]   arlen;
  logic [1:0]   arburst, rresp;
  logic [255:0] rdata;
  logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [7:0]   awid, wid, bid;
  logic [31:0]  awaddr, wstrb;
  logic [2:0]   awsize;
  logic [3:0]   awlen;
  logic [1:0]   awburst, bresp;
  logic [255:0] wdata;

  int checks = 0;
  int errors = 0;

  logic [255:0] wbuf [4];
  logic [255:0] rbuf [4];
  logic [31:0]  wstrb_v;
  logic         wlast_bad;

  always #5 clk = ~clk;

  bank_axi3_mem_slave dut (
    .clk_i(clk), .rst_i(rst),
    .s_axi3_arvalid_i(arvalid), .s_axi3_arready_o(arready), .s_axi3_arid_i(arid),
    .s_axi3_araddr_i(araddr), .s_axi3_arsize_i(arsize), .s_axi3_arlen_i(arlen),
    .s_axi3_arburst_i(arburst), .s_axi3_rvalid_o(rvalid), .s_axi3_rready_i(rready),
    .s_axi3_rid_o(rid), .s_axi3_rdata_o(rdata), .s_axi3_rresp_o(rresp), .s_axi3_rlast_o(rlast),
    .s_axi3_awvalid_i(awvalid), .s_axi3_awready_o(awready), .s_axi3_awid_i(awid),
    .s_axi3_awaddr_i(awaddr), .s_axi3_awsize_i(awsize), .s_axi3_awlen_i(awlen),
    .s_axi3_awburst_i(awburst), .s_axi3_wvalid_i(wvalid), .s_axi3_wready_o(wready),
    .s_axi3_wid_i(wid), .s_axi3_wdata_i(wdata), .s_axi3_wstrb_i(wstrb), .s_axi3_wlast_i(wlast),
    .s_axi3_bvalid_o(bvalid), .s_axi3_bready_i(bready), .s_axi3_bid_o(bid), .s_axi3_bresp_o(bresp)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] w);
    return {8{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [1:0] exp_resp, input string tag);
    int n;
    awvalid = 1'b1; awaddr = addr; awlen = len; awid = id; awsize = size; awburst = burst;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    if (n >= 50) check({tag, "_aw_timeout"}, 0, 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = wstrb_v; wid = id;
      wlast = (i == int'(len)) ^ wlast_bad;
      n = 0;
      while (!wready && n < 50) begin tick(); n++; end
      if (n >= 50) check({tag, "_w_timeout"}, 0, 1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) check({tag, "_b_timeout"}, 0, 1);
    check({tag, "_bresp"}, bresp, exp_resp);
    check({tag, "_bid"}, bid, id);
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id,
                         input logic [2:0] size, input logic [1:0] exp_resp, input string tag);
    int n;
    arvalid = 1'b1; araddr = addr; arlen = len; arid = id; arsize = size; arburst = 2'b01;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    if (n >= 50) check({tag, "_ar_timeout"}, 0, 1);
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      check($sformatf("%s_rvalid%0d", tag, i), rvalid, 1);
      check($sformatf("%s_rlast%0d", tag, i), rlast, (i == int'(len)));
      check($sformatf("%s_rid%0d", tag, i), rid, id);
      check($sformatf("%s_rresp%0d", tag, i), rresp, exp_resp);
      rbuf[i] = rdata;
      tick();
    end
    check({tag, "_rvalid_drop"}, rvalid, 0);
    rready = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    arvalid = 0; arid = 0; araddr = 0; arsize = 3'b101; arlen = 0; arburst = 2'b01; rready = 0;
    awvalid = 0; awid = 0; awaddr = 0; awsize = 3'b101; awlen = 0; awburst = 2'b01;
    wvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    wstrb_v = '1; wlast_bad = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_arready", arready, 1);
    check("rst_awready", awready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_wready", wready, 0);
    check("rst_rdata", rdata, 0);

    // single-beat read of a preloaded line
    wbuf[0] = {32{8'hA5}};
    do_write(32'h60, 4'd0, 8'h01, 3'b101, 2'b01, 2'b00, "pre3");
    do_read(32'h60, 4'd0, 8'h12, 3'b101, 2'b00, "rd3");
    check("rd3_data", rbuf[0], {32{8'hA5}});

    // four-beat burst write then read-back
    for (int i = 0; i < 4; i++) wbuf[i] = line_of(32'hD000_0000 + i);
    do_write(32'h40, 4'd3, 8'h07, 3'b101, 2'b01, 2'b00, "burst_w");
    do_read(32'h40, 4'd3, 8'h21, 3'b101, 2'b00, "burst_r");
    for (int i = 0; i < 4; i++) check($sformatf("burst_data%0d", i), rbuf[i], line_of(32'hD000_0000 + i));

    // partial strobe over an all-ones line
    wbuf[0] = '1;
    do_write(32'h00, 4'd0, 8'h02, 3'b101, 2'b01, 2'b00, "ones");
    wbuf[0] = '0; wstrb_v = 32'h0000_000F;
    do_write(32'h00, 4'd0, 8'h03, 3'b101, 2'b01, 2'b00, "strb");
    wstrb_v = '1;
    do_read(32'h00, 4'd0, 8'h04, 3'b101, 2'b00, "strb_r");
    check("strb_data", rbuf[0], {{224{1'b1}}, 32'h0});

    // error responses: out of range, bad size, bad burst
    do_read(32'h8000_0000, 4'd0, 8'h05, 3'b101, 2'b10, "oor_r");
    check("oor_rdata", rbuf[0], 0);
    do_read(32'h60, 4'd0, 8'h06, 3'b100, 2'b10, "size_r");
    check("size_rdata", rbuf[0], 0);
    wbuf[0] = '0;
    do_write(32'h8000_0000, 4'd0, 8'h08, 3'b101, 2'b01, 2'b10, "oor_w");
    do_write(32'h00, 4'd0, 8'h09, 3'b101, 2'b10, 2'b10, "burst_err_w");
    do_read(32'h00, 4'd0, 8'h0A, 3'b101, 2'b00, "unch_r");
    check("unch_data", rbuf[0], {{224{1'b1}}, 32'h0});

    // single beat with wlast low: written, SLVERR, next AW still accepted
    wlast_bad = 1'b1;
    wbuf[0] = line_of(32'hC5C5_C5C5);
    do_write(32'hA0, 4'd0, 8'h0B, 3'b101, 2'b01, 2'b10, "nolast_w");
    wlast_bad = 1'b0;
    wbuf[0] = line_of(32'h6666_6666);
    do_write(32'hC0, 4'd0, 8'h0C, 3'b101, 2'b01, 2'b00, "after_w");
    do_read(32'hA0, 4'd1, 8'h0D, 3'b101, 2'b00, "nolast_r");
    check("nolast_data", rbuf[0], line_of(32'hC5C5_C5C5));
    check("after_data", rbuf[1], line_of(32'h6666_6666));

    // index wraps from the top line back to line 0
    wbuf[0] = line_of(32'hE000_0000); wbuf[1] = line_of(32'hE000_0001);
    do_write(32'h7FE0, 4'd1, 8'h0E, 3'b101, 2'b01, 2'b00, "wrap_w");
    do_read(32'h00, 4'd0, 8'h0F, 3'b101, 2'b00, "wrap_r");
    check("wrap_data", rbuf[0], line_of(32'hE000_0001));

    // stall mid-burst, then reset during R_DATA
    arvalid = 1'b1; araddr = 32'h40; arlen = 4'd3; arid = 8'h33; arsize = 3'b101; arburst = 2'b01;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    if (n >= 50) check("stall_ar_timeout", 0, 1);
    tick();
    arvalid = 1'b0; rready = 1'b1;
    check("stall_beat0", rdata, line_of(32'hD000_0000));
    tick();
    rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_rvalid%0d", i), rvalid, 1);
      check($sformatf("stall_rdata%0d", i), rdata, line_of(32'hD000_0001));
      check($sformatf("stall_rlast%0d", i), rlast, 0);
      check($sformatf("stall_rid%0d", i), rid, 8'h33);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_arready", arready, 1);
    check("mid_rst_awready", awready, 1);
    check("mid_rst_rlast", rlast, 0);
    check("mid_rst_rid", rid, 0);
    check("mid_rst_rdata", rdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
